// File: rtl/booth_pp_accumulator.sv
// Radix-4 Booth partial-product accumulator: sums NPP signed partial products into one signed product.
// Optional macro BOOTH_ACC_CNT_EN adds a 16-bit count of completed product handshakes (prod_count).
module booth_pp_accumulator #(
    parameter int NPP = 4,
    parameter int PPW = 9,
    parameter int PW  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic signed [PPW-1:0] pp,
    input  logic                  pp_valid,
    output logic                  pp_ready,
    input  logic                  flush,
    output logic signed [PW-1:0]  prod,
    output logic                  prod_valid,
    input  logic                  prod_ready
`ifdef BOOTH_ACC_CNT_EN
    ,
    output logic [15:0]           prod_count
`endif
);

    localparam logic [0:0] ACCUM  = 1'b0;
    localparam logic [0:0] DONE   = 1'b1;
    localparam logic [1:0] K_LAST = 2'(NPP - 1);

    logic [0:0]           r_state;
    logic [1:0]           r_k;
    logic signed [PW-1:0] r_acc;
    logic signed [PW-1:0] r_prod;

    logic                 w_xfer;
    logic                 w_last;
    logic signed [PW-1:0] w_ext;
    logic signed [PW-1:0] w_term;
    logic signed [PW-1:0] w_sum;

    assign pp_ready   = (r_state == ACCUM);
    assign prod_valid = (r_state == DONE);
    assign prod       = r_prod;

    // Flush takes priority over a coincident transfer.
    assign w_xfer = pp_valid && pp_ready && !flush;
    assign w_last = (r_k == K_LAST);

    // Digit k carries weight 4^k; digit 0 restarts the sum so stale acc never leaks in.
    assign w_ext  = {{(PW-PPW){pp[PPW-1]}}, pp};
    assign w_term = w_ext <<< {r_k, 1'b0};
    assign w_sum  = (r_k == 2'd0) ? w_ext : (r_acc + w_term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
            r_k     <= 2'd0;
            r_acc   <= '0;
            r_prod  <= '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (flush) begin
                        r_k   <= 2'd0;
                        r_acc <= '0;
                    end else if (w_xfer) begin
                        r_acc <= w_sum;
                        if (w_last) begin
                            r_k     <= 2'd0;
                            r_prod  <= w_sum;
                            r_state <= DONE;
                        end else begin
                            r_k <= r_k + 2'd1;
                        end
                    end
                end
                DONE: begin
                    if (prod_ready) begin
                        r_state <= ACCUM;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

`ifdef BOOTH_ACC_CNT_EN
    logic [15:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 16'd0;
        end else if (prod_valid && prod_ready) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign prod_count = r_cnt;
`endif

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Directed bench for booth_pp_accumulator: back-to-back products, backpressure, flush and mid-run reset.
module tb_booth_pp_accumulator;

    logic               clk;
    logic               rst_n;
    logic signed [8:0]  pp;
    logic               pp_valid;
    logic               pp_ready;
    logic               flush;
    logic signed [13:0] prod;
    logic               prod_valid;
    logic               prod_ready;
`ifdef BOOTH_ACC_CNT_EN
    logic [15:0]        prod_count;
`endif

    int total = 0;
    int bad   = 0;

    booth_pp_accumulator #(.NPP(4), .PPW(9), .PW(14)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pp         (pp),
        .pp_valid   (pp_valid),
        .pp_ready   (pp_ready),
        .flush      (flush),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready)
`ifdef BOOTH_ACC_CNT_EN
        ,
        .prod_count (prod_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pp(input logic [8:0] v);
        pp       = v;
        pp_valid = 1'b1;
        tick();
        pp_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        pp         = '0;
        pp_valid   = 1'b0;
        flush      = 1'b0;
        prod_ready = 1'b1;
        #1;
        chk("rst_pp_ready", {31'd0, pp_ready}, 32'd1);
        chk("rst_prod_valid", {31'd0, prod_valid}, 32'd0);
        chk("rst_prod", {18'd0, prod}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // 5 x 3
        send_pp(9'h1FB);
        chk("p1_pv_after1", {31'd0, prod_valid}, 32'd0);
        send_pp(9'h005);
        send_pp(9'h000);
        chk("p1_pv_after3", {31'd0, prod_valid}, 32'd0);
        chk("p1_ready_after3", {31'd0, pp_ready}, 32'd1);
        send_pp(9'h000);
        chk("p1_prod_valid", {31'd0, prod_valid}, 32'd1);
        chk("p1_pp_ready", {31'd0, pp_ready}, 32'd0);
        chk("p1_prod", {18'd0, prod}, 32'h000F);
        tick();
        chk("p1_back_accum", {31'd0, prod_valid}, 32'd0);
        chk("p1_prod_held", {18'd0, prod}, 32'h000F);

        // -64 x -64
        send_pp(9'h000);
        send_pp(9'h000);
        send_pp(9'h000);
        send_pp(9'h040);
        chk("p2_prod_valid", {31'd0, prod_valid}, 32'd1);
        chk("p2_prod", {18'd0, prod}, 32'h1000);
        tick();

        // Mixed signs: -1 - 4 + 16 - 64 = -53
        send_pp(9'h1FF);
        send_pp(9'h1FF);
        send_pp(9'h001);
        send_pp(9'h1FF);
        chk("p3_prod", {18'd0, prod}, 32'h3FCB);
        tick();

        // Backpressure in DONE while a new pp is offered
        prod_ready = 1'b0;
        send_pp(9'h001);
        send_pp(9'h001);
        send_pp(9'h000);
        send_pp(9'h000);
        chk("bp_prod", {18'd0, prod}, 32'h0005);
        pp       = 9'h0AA;
        pp_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_pp_ready", {31'd0, pp_ready}, 32'd0);
            chk("bp_prod_valid", {31'd0, prod_valid}, 32'd1);
            chk("bp_prod_stable", {18'd0, prod}, 32'h0005);
        end
        prod_ready = 1'b1;
        tick();
        chk("bp_released", {31'd0, prod_valid}, 32'd0);
        chk("bp_ready_again", {31'd0, pp_ready}, 32'd1);
        tick();
        pp_valid = 1'b0;
        send_pp(9'h000);
        send_pp(9'h000);
        send_pp(9'h000);
        chk("bp_next_prod_valid", {31'd0, prod_valid}, 32'd1);
        chk("bp_next_prod", {18'd0, prod}, 32'h00AA);
        tick();

        // Flush wins over a coincident pp
        send_pp(9'h0F0);
        send_pp(9'h0F0);
        pp       = 9'h0F0;
        pp_valid = 1'b1;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        pp_valid = 1'b0;
        chk("fl_no_done", {31'd0, prod_valid}, 32'd0);
        send_pp(9'h002);
        send_pp(9'h000);
        send_pp(9'h000);
        chk("fl_not_early", {31'd0, prod_valid}, 32'd0);
        send_pp(9'h000);
        chk("fl_prod_valid", {31'd0, prod_valid}, 32'd1);
        chk("fl_prod", {18'd0, prod}, 32'h0002);
        // Flush in DONE must not drop the pending product
        prod_ready = 1'b0;
        flush      = 1'b1;
        tick();
        flush      = 1'b0;
        chk("fl_done_kept", {31'd0, prod_valid}, 32'd1);
        chk("fl_done_prod", {18'd0, prod}, 32'h0002);
        prod_ready = 1'b1;
        tick();

        // Reset mid-accumulation
        send_pp(9'h07F);
        send_pp(9'h07F);
        rst_n = 1'b0;
        #1;
        chk("mr_prod_valid", {31'd0, prod_valid}, 32'd0);
        chk("mr_pp_ready", {31'd0, pp_ready}, 32'd1);
        chk("mr_prod", {18'd0, prod}, 32'h0);
        tick();
        chk("mr_prod_valid_hold", {31'd0, prod_valid}, 32'd0);
        rst_n = 1'b1;
        send_pp(9'h1FB);
        send_pp(9'h005);
        send_pp(9'h000);
        send_pp(9'h000);
        chk("mr_prod_valid_after", {31'd0, prod_valid}, 32'd1);
        chk("mr_prod_after", {18'd0, prod}, 32'h000F);
        tick();
`ifdef BOOTH_ACC_CNT_EN
        chk("cnt_after_reset", {16'd0, prod_count}, 32'd1);
`endif
        chk("end_accum", {31'd0, pp_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
